masked_rr_arbiter: RTL and testbench

MASKED_RR_ARBITER -- requirements
Module: masked_rr_arbiter

---
 rtl/masked_rr_arbiter.sv | 113 +++++++++++
 tb/tb_masked_rr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/masked_rr_arbiter.sv
// Round-robin arbiter with per-requester masking, hold-time watchdog and
// back-to-back re-arbitration on release.
//
// state | meaning
// IDLE  | no grant active, waiting for an eligible requester
// GRANT | gnt_id owns the resource until done, request drop or timeout
module masked_rr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = $clog2(WIDTH),
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  input  logic [WIDTH-1:0]     mask,
  input  logic                 done,
  output logic                 gnt_valid,
  output logic [OUT_WIDTH-1:0] gnt_id,
  output logic [WIDTH-1:0]     gnt_onehot,
  output logic                 timeout_err
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [OUT_WIDTH-1:0] ptr;
  logic [7:0]           hold_cnt;

  logic [WIDTH-1:0]     eligible;
  logic                 normal_rel;
  logic                 timeout_hit;
  logic                 release_now;
  logic [OUT_WIDTH-1:0] next_ptr;
  logic [OUT_WIDTH-1:0] arb_ptr;
  logic [WIDTH-1:0]     arb_vec;
  logic                 arb_found;
  logic [OUT_WIDTH-1:0] arb_id;
  logic [WIDTH-1:0]     arb_onehot;

  always_comb begin
    eligible    = req & ~mask;
    normal_rel  = (state == GRANT) && (done || !req[gnt_id]);
    timeout_hit = (state == GRANT) && (hold_cnt == 8'(TIMEOUT - 1));
    release_now = normal_rel || timeout_hit;
    next_ptr    = (gnt_id == OUT_WIDTH'(WIDTH - 1)) ? '0 : gnt_id + 1'b1;
    // On release the search starts past the holder, which is also excluded
    arb_ptr     = (state == GRANT) ? next_ptr : ptr;
    arb_vec     = (state == GRANT) ? (eligible & ~gnt_onehot) : eligible;
  end

  always_comb begin
    int idx;
    logic [OUT_WIDTH-1:0] idx_w;
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = int'(arb_ptr) + i;
      if (idx >= WIDTH) idx = idx - WIDTH;
      idx_w = OUT_WIDTH'(idx);
      if (!arb_found && arb_vec[idx_w]) begin
        arb_found = 1'b1;
        arb_id    = idx_w;
      end
    end
    arb_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << arb_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt_valid   <= 1'b0;
      gnt_id      <= '0;
      gnt_onehot  <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_id     <= arb_id;
            gnt_onehot <= arb_onehot;
            hold_cnt   <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr         <= next_ptr;
            timeout_err <= timeout_hit && !normal_rel;
            if (arb_found) begin
              gnt_id     <= arb_id;
              gnt_onehot <= arb_onehot;
              hold_cnt   <= '0;
            end else begin
              state      <= IDLE;
              gnt_valid  <= 1'b0;
              gnt_onehot <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_masked_rr_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural round-robin model that counts visible grant cycles.
module tb_masked_rr_arbiter;

  localparam int W  = 16;
  localparam int OW = 4;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  req;
  logic [W-1:0]  mask;
  logic          done;
  logic          gnt_valid;
  logic [OW-1:0] gnt_id;
  logic [W-1:0]  gnt_onehot;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // model state
  bit m_busy = 0;
  int m_id   = 0;
  int m_ptr  = 0;
  int m_age  = 0;
  bit m_terr = 0;

  masked_rr_arbiter #(.WIDTH(W), .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .done(done),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_onehot(gnt_onehot),
    .timeout_err(timeout_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // first eligible index at or after start, wrapping, skipping excl
  function automatic int pick(input logic [W-1:0] vec, input int start, input int excl);
    for (int off = 0; off < W; off++) begin
      int idx;
      idx = (start + off) % W;
      if (vec[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    bit normal;
    if (rst) begin
      m_busy = 0; m_id = 0; m_ptr = 0; m_age = 0; m_terr = 0;
    end else begin
      m_terr = 0;
      if (!m_busy) begin
        w = pick(req & ~mask, m_ptr, -1);
        if (w >= 0) begin m_busy = 1; m_id = w; m_age = 1; end
      end else begin
        normal = done || !req[m_id];
        if (normal || m_age == TO) begin
          m_terr = !normal;
          m_ptr  = (m_id + 1) % W;
          w = pick(req & ~mask, m_ptr, m_id);
          if (w >= 0) begin m_id = w; m_age = 1; end
          else m_busy = 0;
        end else begin
          m_age++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", 32'(gnt_valid), 32'(m_busy));
      chk("cyc_id", 32'(gnt_id), 32'(m_id));
      chk("cyc_onehot", 32'(gnt_onehot), m_busy ? (32'd1 << m_id) : 32'd0);
      chk("cyc_terr", 32'(timeout_err), 32'(m_terr));
    end
  end

  task automatic drive(input logic [W-1:0] r, input logic [W-1:0] m, input logic d, input logic rs);
    req = r; mask = m; done = d; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; req = '0; mask = '0; done = 0;
    #2;
    drive(16'h0, 16'h0, 0, 1);
    chk_en = 1;
    drive(16'h0, 16'h0, 0, 1);
    chk("rst_valid", 32'(gnt_valid), 0);
    chk("rst_id", 32'(gnt_id), 0);
    chk("rst_onehot", 32'(gnt_onehot), 0);
    chk("rst_terr", 32'(timeout_err), 0);

    // two requesters, done hands over without a bubble
    drive(16'h0011, 16'h0, 0, 0);
    chk("r28_first", 32'(gnt_id), 0);
    drive(16'h0011, 16'h0, 1, 0);
    chk("r28_second", 32'(gnt_id), 4);
    chk("r28_valid", 32'(gnt_valid), 1);
    drive(16'h0011, 16'h0, 1, 0);
    chk("r28_wrap", 32'(gnt_id), 0);
    drive(16'h0, 16'h0, 0, 0);
    chk("r28_drop", 32'(gnt_valid), 0);

    // masked requester 0; sole requester regranted via idle
    drive(16'h0, 16'h0, 0, 1);
    drive(16'h8001, 16'h0001, 0, 0);
    chk("r29_id", 32'(gnt_id), 15);
    chk("r29_onehot", 32'(gnt_onehot), 32'h8000);
    drive(16'h8001, 16'h0001, 1, 0);
    chk("r29_idle", 32'(gnt_valid), 0);
    chk("r29_onehot0", 32'(gnt_onehot), 0);
    chk("r29_idheld", 32'(gnt_id), 15);
    chk("r29_ptr", 32'(m_ptr), 0);
    drive(16'h8001, 16'h0001, 0, 0);
    chk("r25_regrant", 32'(gnt_id), 15);
    chk("r25_valid", 32'(gnt_valid), 1);

    // full rotation
    drive(16'h0, 16'h0, 0, 1);
    drive(16'hFFFF, 16'h0, 0, 0);
    chk("r30_0", 32'(gnt_id), 0);
    for (int k = 1; k <= 16; k++) begin
      drive(16'hFFFF, 16'h0, 1, 0);
      chk("r30_order", 32'(gnt_id), 32'(k % 16));
    end

    // watchdog
    drive(16'h0, 16'h0, 0, 1);
    drive(16'h0006, 16'h0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(16'h0006, 16'h0, 0, 0);
      chk("r31_hold", 32'(gnt_id), 1);
      chk("r31_noterr", 32'(timeout_err), 0);
    end
    drive(16'h0006, 16'h0, 0, 0);
    chk("r31_next", 32'(gnt_id), 2);
    chk("r31_terr", 32'(timeout_err), 1);
    drive(16'h0006, 16'h0, 0, 0);
    chk("r31_pulse1", 32'(timeout_err), 0);
    drive(16'h0006, 16'h0, 0, 0);
    drive(16'h0006, 16'h0, 0, 0);
    drive(16'h0006, 16'h0, 1, 0);
    chk("r23_terr", 32'(timeout_err), 0);
    chk("r23_id", 32'(gnt_id), 1);

    // mask changes do not revoke
    drive(16'h0, 16'h0, 0, 1);
    drive(16'h0008, 16'h0, 0, 0);
    chk("r32_id", 32'(gnt_id), 3);
    drive(16'h0008, 16'hFFFF, 0, 0);
    drive(16'h0008, 16'hFFFF, 0, 0);
    chk("r32_held", 32'(gnt_id), 3);
    chk("r32_valid", 32'(gnt_valid), 1);
    drive(16'h0008, 16'hFFFF, 1, 0);
    chk("r32_idle", 32'(gnt_valid), 0);

    // reset mid-grant
    drive(16'h0080, 16'h0, 0, 0);
    chk("r33_id", 32'(gnt_id), 7);
    drive(16'h0080, 16'h0, 0, 1);
    chk("r33_rvalid", 32'(gnt_valid), 0);
    chk("r33_rid", 32'(gnt_id), 0);
    chk("r33_rterr", 32'(timeout_err), 0);
    drive(16'h0080, 16'h0, 0, 0);
    chk("r33_regrant", 32'(gnt_id), 7);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] r, m;
      r = ($urandom_range(0, 3) == 0) ? W'($urandom) & W'($urandom) & W'($urandom) : W'($urandom);
      m = W'($urandom) & W'($urandom) & W'($urandom);
      drive(r, m, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
